// File: rtl/pong_pkg.sv
// pong_pkg: shared widths, winner codes and FSM state encoding for the goal tracker
package pong_pkg;
    localparam int X_W = 10;
    localparam int Y_W = 9;
    localparam logic [2:0] WIN_NONE    = 3'd0;
    localparam logic [2:0] WIN_P1_GAME = 3'd1;
    localparam logic [2:0] WIN_P2_GAME = 3'd2;
    localparam logic [2:0] WIN_P1_PT   = 3'd3;
    localparam logic [2:0] WIN_P2_PT   = 3'd4;
    typedef enum logic [1:0] {IDLE, PLAY, HOLD, OVER} state_t;
endpackage

// File: rtl/pong_goal_tracker_if.sv
// pong_goal_tracker_if: frame/ball/segment inputs and score/winner outputs of the goal tracker
//   slave  (tracker): screenEnd, game_start, ball_x/y, seg bounds in; frame_tick, lat, scores, winner, ball_reset, busy out
//   master (game side): the mirror image
interface pong_goal_tracker_if #(
    parameter int X_W     = pong_pkg::X_W,
    parameter int Y_W     = pong_pkg::Y_W,
    parameter int SCORE_W = 4
);
    logic               screenEnd;
    logic               game_start;
    logic [X_W-1:0]     ball_x;
    logic [Y_W-1:0]     ball_y;
    logic [Y_W-1:0]     segLeft_topBound;
    logic [Y_W-1:0]     segLeft_bottomBound;
    logic [Y_W-1:0]     segRight_topBound;
    logic [Y_W-1:0]     segRight_bottomBound;
    logic               frame_tick;
    logic [X_W-1:0]     ball_x_lat;
    logic [Y_W-1:0]     ball_y_lat;
    logic [SCORE_W-1:0] p1_score;
    logic [SCORE_W-1:0] p2_score;
    logic [2:0]         winner;
    logic               ball_reset;
    logic               busy;
    modport slave (
        input  screenEnd, game_start, ball_x, ball_y,
               segLeft_topBound, segLeft_bottomBound, segRight_topBound, segRight_bottomBound,
        output frame_tick, ball_x_lat, ball_y_lat, p1_score, p2_score, winner, ball_reset, busy
    );
    modport master (
        output screenEnd, game_start, ball_x, ball_y,
               segLeft_topBound, segLeft_bottomBound, segRight_topBound, segRight_bottomBound,
        input  frame_tick, ball_x_lat, ball_y_lat, p1_score, p2_score, winner, ball_reset, busy
    );
endinterface

// File: rtl/pong_goal_tracker_screen_end_edge.sv
// screen_end_edge: rising-edge detector on the screenEnd level
//   clock, reset : clock and synchronous active-high reset
//   screenEnd    : frame strobe level
//   rise         : combinational edge seen at the coming clock edge (used to latch the ball)
//   tick         : registered one-cycle frame pulse
module screen_end_edge (
    input  logic clock,
    input  logic reset,
    input  logic screenEnd,
    output logic rise,
    output logic tick
);
    logic se_q;
    logic tick_q;
    assign rise = screenEnd & ~se_q;
    assign tick = tick_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            se_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            se_q   <= screenEnd;
            tick_q <= rise;
        end
    end
endmodule

// File: rtl/pong_goal_tracker.sv
// pong_goal_tracker: per-frame ball sampling, goal detection, scoring and point/game-over sequencing
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : screenEnd/game_start/ball/segment inputs; frame_tick, latched ball, scores,
//                  winner code, ball_reset pulse and busy outputs
//   Macro PONG_SEG_CHECK_EN: when defined, a goal also needs the latched y inside the goal segment.
module pong_goal_tracker #(
    parameter int X_W          = pong_pkg::X_W,
    parameter int Y_W          = pong_pkg::Y_W,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 7,
    parameter int HOLD_FRAMES  = 60,
    parameter int LEFT_GOAL_X  = 4,
    parameter int RIGHT_GOAL_X = 628
) (
    input logic          clock,
    input logic          reset,
    pong_goal_tracker_if.slave bus
);
    import pong_pkg::*;
    localparam int HC_W = $clog2(HOLD_FRAMES + 1);
    if (WIN_SCORE < 1 || WIN_SCORE >= (1 << SCORE_W)) begin : g_bad_win
        $error("WIN_SCORE must be in 1 .. 2**SCORE_W-1");
    end
    if (HOLD_FRAMES < 1) begin : g_bad_hold
        $error("HOLD_FRAMES must be at least 1");
    end
    logic               rise;
    logic               tick;
    state_t             state_q, state_d;
    logic [X_W-1:0]     x_lat_q;
    logic [Y_W-1:0]     y_lat_q;
    logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
    logic [2:0]         win_q, win_d;
    logic               br_q, br_d;
    logic [HC_W-1:0]    hold_q, hold_d;
    logic               in_l, in_r, goal_l, goal_r;
    screen_end_edge u_edge (
        .clock     (clock),
        .reset     (reset),
        .screenEnd (bus.screenEnd),
        .rise      (rise),
        .tick      (tick)
    );
`ifdef PONG_SEG_CHECK_EN
    assign in_l = (y_lat_q >= bus.segLeft_topBound)  && (y_lat_q <= bus.segLeft_bottomBound);
    assign in_r = (y_lat_q >= bus.segRight_topBound) && (y_lat_q <= bus.segRight_bottomBound);
`else
    assign in_l = 1'b1;
    assign in_r = 1'b1;
`endif
    // left wins when both sides match (only possible with odd parameters)
    assign goal_l = (x_lat_q <= X_W'(LEFT_GOAL_X)) && in_l;
    assign goal_r = (x_lat_q >= X_W'(RIGHT_GOAL_X)) && in_r && !goal_l;
    always_comb begin
        state_d = state_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        win_d   = win_q;
        br_d    = 1'b0;
        hold_d  = hold_q;
        if (bus.game_start) begin
            state_d = PLAY;
            p1_d    = '0;
            p2_d    = '0;
            win_d   = WIN_NONE;
            br_d    = 1'b1;
            hold_d  = '0;
        end else if (state_q == PLAY && tick && (goal_l || goal_r)) begin
            p1_d    = goal_r ? p1_q + SCORE_W'(1) : p1_q;
            p2_d    = goal_l ? p2_q + SCORE_W'(1) : p2_q;
            br_d    = 1'b1;
            hold_d  = '0;
            if (p1_d == SCORE_W'(WIN_SCORE) || p2_d == SCORE_W'(WIN_SCORE)) begin
                state_d = OVER;
                win_d   = goal_l ? WIN_P2_GAME : WIN_P1_GAME;
            end else begin
                state_d = HOLD;
                win_d   = goal_l ? WIN_P2_PT : WIN_P1_PT;
            end
        end else if (state_q == HOLD && tick) begin
            state_d = (hold_q == HC_W'(HOLD_FRAMES - 1)) ? PLAY : HOLD;
            win_d   = (hold_q == HC_W'(HOLD_FRAMES - 1)) ? WIN_NONE : win_q;
            hold_d  = hold_q + HC_W'(1);
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            x_lat_q <= '0;
            y_lat_q <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
            win_q   <= WIN_NONE;
            br_q    <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            x_lat_q <= rise ? bus.ball_x : x_lat_q;
            y_lat_q <= rise ? bus.ball_y : y_lat_q;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            win_q   <= win_d;
            br_q    <= br_d;
            hold_q  <= hold_d;
        end
    end
    assign bus.frame_tick = tick;
    assign bus.ball_x_lat = x_lat_q;
    assign bus.ball_y_lat = y_lat_q;
    assign bus.p1_score   = p1_q;
    assign bus.p2_score   = p2_q;
    assign bus.winner     = win_q;
    assign bus.ball_reset = br_q;
    assign bus.busy       = (state_q == PLAY) || (state_q == HOLD);
endmodule

// File: tb/tb_pong_goal_tracker.sv
// tb_pong_goal_tracker: randomized scoreboard bench for pong_goal_tracker
module tb_pong_goal_tracker;
    localparam int WIN = 3, HOLD = 3, LX = 4, RX = 628;
    localparam int SL_T = 200, SL_B = 280, SR_T = 200, SR_B = 280;
    typedef struct {int x; int y; int p1; int p2; int win; int busy; int br;} rec_t;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;
    pong_goal_tracker_if #(.X_W(10), .Y_W(9), .SCORE_W(4)) bus ();
    pong_goal_tracker #(
        .X_W(10), .Y_W(9), .SCORE_W(4), .WIN_SCORE(WIN), .HOLD_FRAMES(HOLD),
        .LEFT_GOAL_X(LX), .RIGHT_GOAL_X(RX)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );
    rec_t fq[$];
    rec_t sq[$];
    int n_cmp = 0, n_bad = 0;
    // game-level model: mode 0 idle, 1 playing, 2 frozen after a point, 3 game over
    int m_mode = 0, m_p1 = 0, m_p2 = 0, m_win = 0, m_hold = 0;
    task automatic chk(string name, logic [31:0] act, int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic snap(output rec_t r, input int x, input int y, input int br);
        r.x = x; r.y = y; r.br = br;
        r.p1 = m_p1; r.p2 = m_p2; r.win = m_win;
        r.busy = (m_mode == 1 || m_mode == 2) ? 1 : 0;
    endtask
    task automatic model_start();
        m_p1 = 0; m_p2 = 0; m_win = 0; m_mode = 1; m_hold = 0;
    endtask
    task automatic model_frame(input int x, input int y, output int br);
        bit gl, gr;
        gl = x <= LX;
        gr = x >= RX;
`ifdef PONG_SEG_CHECK_EN
        gl = gl && y >= SL_T && y <= SL_B;
        gr = gr && y >= SR_T && y <= SR_B;
`endif
        br = 0;
        if (m_mode == 1 && (gl || gr)) begin
            br = 1;
            if (gl) m_p2++; else m_p1++;
            if (m_p1 == WIN || m_p2 == WIN) begin
                m_mode = 3; m_win = gl ? 2 : 1;
            end else begin
                m_mode = 2; m_hold = 0; m_win = gl ? 4 : 3;
            end
        end else if (m_mode == 2) begin
            m_hold++;
            if (m_hold == HOLD) begin m_mode = 1; m_win = 0; end
        end
    endtask
    task automatic frame(input int x, input int y, input bit ws, input int hi, input int lo);
        rec_t r;
        int br;
        @(negedge clock);
        bus.ball_x = 10'(x);
        bus.ball_y = 9'(y);
        bus.screenEnd = 1'b1;
        model_frame(x, y, br);
        if (ws) begin model_start(); br = 1; end
        snap(r, x, y, br);
        fq.push_back(r);
        @(negedge clock);
        if (ws) bus.game_start = 1'b1;
        @(negedge clock);
        bus.game_start = 1'b0;
        repeat (hi > 2 ? hi - 2 : 0) @(negedge clock);
        bus.screenEnd = 1'b0;
        repeat (lo) @(negedge clock);
    endtask
    task automatic start();
        rec_t r;
        @(negedge clock);
        bus.game_start = 1'b1;
        model_start();
        snap(r, 0, 0, 1);
        sq.push_back(r);
        @(negedge clock);
        bus.game_start = 1'b0;
        repeat (2) @(negedge clock);
    endtask
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.screenEnd = 1'b0;
        bus.game_start = 1'b0;
        @(negedge clock);
        chk("rst_tick", bus.frame_tick, 0);
        chk("rst_xlat", bus.ball_x_lat, 0);
        chk("rst_ylat", bus.ball_y_lat, 0);
        chk("rst_p1", bus.p1_score, 0);
        chk("rst_p2", bus.p2_score, 0);
        chk("rst_winner", bus.winner, 0);
        chk("rst_ball_reset", bus.ball_reset, 0);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b0;
        m_mode = 0; m_p1 = 0; m_p2 = 0; m_win = 0; m_hold = 0;
        repeat (2) @(negedge clock);
    endtask
    initial begin : monitor
        rec_t r;
        forever begin
            @(negedge clock);
            if (reset) continue;
            if (bus.frame_tick) begin
                if (fq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL frame_tick: got 1 expected 0 (no frame pending)");
                end else begin
                    r = fq.pop_front();
                    chk("ball_x_lat", bus.ball_x_lat, r.x);
                    chk("ball_y_lat", bus.ball_y_lat, r.y);
                    @(negedge clock);
                    chk("frame_tick_width", bus.frame_tick, 0);
                    chk("p1_score", bus.p1_score, r.p1);
                    chk("p2_score", bus.p2_score, r.p2);
                    chk("winner", bus.winner, r.win);
                    chk("busy", bus.busy, r.busy);
                    chk("ball_reset", bus.ball_reset, r.br);
                end
            end else if (bus.ball_reset) begin
                if (sq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL ball_reset: got 1 expected 0 (no start pending)");
                end else begin
                    r = sq.pop_front();
                    chk("start_p1", bus.p1_score, r.p1);
                    chk("start_p2", bus.p2_score, r.p2);
                    chk("start_winner", bus.winner, r.win);
                    chk("start_busy", bus.busy, r.busy);
                end
            end
        end
    end
    initial begin : stim
        int x, y, k;
        bus.screenEnd = 1'b0;
        bus.game_start = 1'b0;
        bus.ball_x = '0;
        bus.ball_y = '0;
        bus.segLeft_topBound = 9'(SL_T);
        bus.segLeft_bottomBound = 9'(SL_B);
        bus.segRight_topBound = 9'(SR_T);
        bus.segRight_bottomBound = 9'(SR_B);
        repeat (3) @(negedge clock);
        do_reset();
        frame(2, 240, 0, 2, 2);
        start();
        frame(2, 240, 0, 2, 2);
        for (int i = 0; i < HOLD; i++) frame(2, 240, 0, 2, 2);
        frame(300, 240, 0, 3, 2);
        for (int i = 0; i < WIN; i++) begin
            frame(630, 240, 0, 2, 2);
            if (m_mode == 2) for (int j = 0; j < HOLD; j++) frame(630, 240, 0, 2, 2);
        end
        frame(2, 240, 0, 2, 2);
        frame(630, 240, 0, 2, 2);
        start();
        frame(630, 100, 0, 2, 2);
        frame(300, 240, 0, 10, 3);
        for (int i = 0; i < 3; i++) frame(400 + i, 50, 0, 5, 5);
        while (m_mode == 2) frame(300, 240, 0, 2, 2);
        frame(2, 240, 0, 2, 2);
        do_reset();
        start();
        frame(2, 240, 1, 3, 2);
        frame(300, 240, 0, 2, 2);
        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, 9);
            x = (k < 2) ? $urandom_range(0, 6) : (k < 4) ? $urandom_range(626, 1023) : $urandom_range(5, 627);
            y = $urandom_range(150, 330);
            if (m_mode == 0 || m_mode == 3 || $urandom_range(0, 29) == 0) start();
            if ($urandom_range(0, 39) == 0) do_reset();
            frame(x, y, $urandom_range(0, 24) == 0, $urandom_range(1, 4), $urandom_range(1, 3));
        end
        repeat (5) @(negedge clock);
        chk("frames_drained", fq.size(), 0);
        chk("starts_drained", sq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
